// File: rtl/modn_updown_counter.sv
// Modulo-MODULUS up/down counter with parallel load, an out-of-range load flag and a
// combinational cascade strobe. Optional saturating wrap counter behind MODN_CNT_WRAP_COUNT_EN.
module modn_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_out,
  output logic             load_err
`ifdef MODN_CNT_WRAP_COUNT_EN
  ,
  output logic [7:0]       wrap_count
`endif
);

  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

  logic at_top;
  logic at_bot;
  logic in_range;

  // Explicit wraps at the range ends; with MODULUS == 2**WIDTH they coincide with natural overflow.
  function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] cur, input logic up);
    if (up) return (cur == TOP) ? '0 : cur + WIDTH'(1);
    else    return (cur == '0) ? TOP : cur - WIDTH'(1);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign at_top   = (data_out == TOP);
  assign at_bot   = (data_out == '0);
  assign in_range = ({1'b0, data_in} < MOD_EXT);

  // High in the cycle before a wrap, so the next stage's en sees it on the same edge.
  assign carry_out = en & ~load & ~rst & ((mode & at_top) | (~mode & at_bot));

  always_ff @(posedge clock) begin
    if (rst) begin
      data_out <= '0;
      load_err <= 1'b0;
    end else if (load) begin
      data_out <= in_range ? data_in : TOP;
      load_err <= ~in_range;
    end else begin
      load_err <= 1'b0;
      if (en) data_out <= step_count(data_out, mode);
    end
  end

`ifdef MODN_CNT_WRAP_COUNT_EN
  always_ff @(posedge clock) begin
    if (rst) begin
      wrap_count <= '0;
    end else if (carry_out) begin
      wrap_count <= sat_inc(wrap_count);
    end
  end
`endif

endmodule

// File: tb/tb_modn_updown_counter.sv
// Self-checking bench for modn_updown_counter: vector table + scoreboard on a MODULUS=10 instance,
// a two-stage cascade, and a MODULUS=16 instance (wrap_count checked when MODN_CNT_WRAP_COUNT_EN is set).
module tb_modn_updown_counter;

  typedef struct {
    logic       r;
    logic       ld;
    logic       e;
    logic       m;
    logic [3:0] din;
    logic       ecarry;
    logic [3:0] eout;
    logic       eerr;
  } vec_t;

  typedef struct {
    logic [3:0] out;
    logic       err;
    string      tag;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_miss = 0;

  vec_t vecs[$];
  exp_t sb[$];

  // Main instance, defaults
  logic       rst = 1'b1, en = 1'b0, mode = 1'b0, load = 1'b0;
  logic [3:0] data_in = '0;
  logic [3:0] data_out;
  logic       carry_out, load_err;
`ifdef MODN_CNT_WRAP_COUNT_EN
  logic [7:0] d_wc;
`endif

  modn_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clock(clock), .rst(rst), .en(en), .mode(mode), .load(load),
    .data_in(data_in), .data_out(data_out), .carry_out(carry_out), .load_err(load_err)
`ifdef MODN_CNT_WRAP_COUNT_EN
    , .wrap_count(d_wc)
`endif
  );

  // Two-stage cascade
  logic       c_rst = 1'b1, c_en = 1'b0;
  logic [3:0] lo_out, hi_out;
  logic       lo_carry, hi_carry, lo_err, hi_err;
`ifdef MODN_CNT_WRAP_COUNT_EN
  logic [7:0] lo_wc, hi_wc;
`endif

  modn_updown_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
    .clock(clock), .rst(c_rst), .en(c_en), .mode(1'b1), .load(1'b0),
    .data_in(4'd0), .data_out(lo_out), .carry_out(lo_carry), .load_err(lo_err)
`ifdef MODN_CNT_WRAP_COUNT_EN
    , .wrap_count(lo_wc)
`endif
  );

  modn_updown_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
    .clock(clock), .rst(c_rst), .en(lo_carry), .mode(1'b1), .load(1'b0),
    .data_in(4'd0), .data_out(hi_out), .carry_out(hi_carry), .load_err(hi_err)
`ifdef MODN_CNT_WRAP_COUNT_EN
    , .wrap_count(hi_wc)
`endif
  );

  // Full-range instance
  logic       w_rst = 1'b1, w_en = 1'b0, w_mode = 1'b1, w_load = 1'b0;
  logic [3:0] w_din = '0;
  logic [3:0] w_out;
  logic       w_carry, w_err;
`ifdef MODN_CNT_WRAP_COUNT_EN
  logic [7:0] w_wc;
`endif

  modn_updown_counter #(.WIDTH(4), .MODULUS(16)) u_w (
    .clock(clock), .rst(w_rst), .en(w_en), .mode(w_mode), .load(w_load),
    .data_in(w_din), .data_out(w_out), .carry_out(w_carry), .load_err(w_err)
`ifdef MODN_CNT_WRAP_COUNT_EN
    , .wrap_count(w_wc)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic ld, input logic e, input logic m,
                              input logic [3:0] din, input logic ec, input logic [3:0] eo,
                              input logic ee);
    vec_t v;
    v.r = r; v.ld = ld; v.e = e; v.m = m; v.din = din;
    v.ecarry = ec; v.eout = eo; v.eerr = ee;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    exp_t x;
    @(negedge clock);
    rst = v.r; load = v.ld; en = v.e; mode = v.m; data_in = v.din;
    #1;
    chk({tag, ".carry"}, carry_out, v.ecarry);
    sb.push_back('{v.eout, v.eerr, tag});
    @(posedge clock);
    #1;
    x = sb.pop_front();
    chk({x.tag, ".data_out"}, data_out, x.out);
    chk({x.tag, ".load_err"}, load_err, x.err);
  endtask

  initial begin
    int   m_cnt;
    vec_t v;
    logic r, ld, e, m, ec, ee;
    logic [3:0] din;

    // Vector table: {rst, load, en, mode, data_in, carry, data_out after edge, load_err after edge}
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 12; i++)
      vecs.push_back(mk(0, 0, 1, 1, 0, (i == 10), 4'(i % 10), 0));
    vecs.push_back(mk(0, 1, 1, 1, 3, 0, 3, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 2, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 9, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 8, 0));
    vecs.push_back(mk(0, 1, 0, 0, 13, 0, 9, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 9, 0));
    vecs.push_back(mk(0, 1, 1, 0, 7, 0, 7, 0));
    vecs.push_back(mk(0, 1, 0, 1, 10, 0, 9, 1));
    vecs.push_back(mk(0, 1, 0, 1, 15, 0, 9, 1));
    vecs.push_back(mk(0, 1, 0, 0, 9, 0, 9, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 9, 0));
    vecs.push_back(mk(0, 1, 1, 1, 9, 0, 9, 0));
    vecs.push_back(mk(0, 1, 0, 0, 5, 0, 5, 0));
    vecs.push_back(mk(1, 1, 1, 1, 2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 9, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4, 0, 4, 0));
    vecs.push_back(mk(1, 1, 0, 0, 12, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 9, 0, 9, 0));
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0));

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("vec%0d", i));

    // Random traffic against a reference model, starting from a reset
    m_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      r   = (i == 0) || ($urandom_range(0, 19) == 0);
      ld  = ($urandom_range(0, 7) == 0);
      e   = ($urandom_range(0, 3) != 0);
      m   = 1'($urandom_range(0, 1));
      din = 4'($urandom_range(0, 15));
      ec  = e && !ld && !r && ((m && m_cnt == 9) || (!m && m_cnt == 0));
      ee  = 1'b0;
      if (r) m_cnt = 0;
      else if (ld) begin
        if (din < 10) m_cnt = din;
        else begin m_cnt = 9; ee = 1'b1; end
      end else if (e) begin
        if (m) m_cnt = (m_cnt == 9) ? 0 : m_cnt + 1;
        else   m_cnt = (m_cnt == 0) ? 9 : m_cnt - 1;
      end
      v = mk(r, ld, e, m, din, ec, 4'(m_cnt), ee);
      apply(v, $sformatf("rand%0d", i));
    end

    // Cascade: {hi,lo} tracks the cycle count modulo 100
    @(negedge clock); c_rst = 1'b1; c_en = 1'b0;
    @(posedge clock); #1;
    chk("casc.reset", hi_out * 10 + lo_out, 0);
    @(negedge clock); c_rst = 1'b0; c_en = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clock); #1;
      chk($sformatf("casc.count%0d", k), hi_out * 10 + lo_out, k % 100);
      chk($sformatf("casc.hi_carry%0d", k), hi_carry, (k % 100) == 99);
    end

    // Full-range instance: natural overflow and wrap counting
    @(negedge clock); w_rst = 1'b1;
    @(posedge clock); #1;
    chk("w.reset.out", w_out, 0);
`ifdef MODN_CNT_WRAP_COUNT_EN
    chk("w.reset.wc", w_wc, 0);
`endif
    @(negedge clock); w_rst = 1'b0; w_en = 1'b1; w_mode = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    chk("w.up40.out", w_out, 8);
`ifdef MODN_CNT_WRAP_COUNT_EN
    chk("w.up40.wc", w_wc, 2);
`endif
    @(negedge clock); w_load = 1'b1; w_din = 4'd3;
    @(posedge clock); #1;
    chk("w.load.out", w_out, 3);
    chk("w.load.err", w_err, 0);
`ifdef MODN_CNT_WRAP_COUNT_EN
    chk("w.load.wc", w_wc, 2);
`endif
    @(negedge clock); w_load = 1'b0; w_mode = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("w.down.out", w_out, 15);
`ifdef MODN_CNT_WRAP_COUNT_EN
    chk("w.down.wc", w_wc, 3);
`endif
    @(negedge clock); w_mode = 1'b1;
    repeat (4200) @(posedge clock);
    #1;
    chk("w.sat.out", w_out, 7);
`ifdef MODN_CNT_WRAP_COUNT_EN
    chk("w.sat.wc", w_wc, 255);
`endif
    @(negedge clock); w_rst = 1'b1;
    @(posedge clock); #1;
    chk("w.rst2.out", w_out, 0);
`ifdef MODN_CNT_WRAP_COUNT_EN
    chk("w.rst2.wc", w_wc, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/modn_updown_counter.md
MODN_UPDOWN_COUNTER -- requirements
Module: modn_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits; SHALL be >= 1.
REQ-002 Parameter MODULUS, default 10, count range 0..MODULUS-1; SHALL satisfy 2 <= MODULUS <= 2**WIDTH.
REQ-003 Port clock  in  1  sole clock; all state SHALL update on posedge clock.
REQ-004 Port rst  in  1  reset; synchronous, active-high.
REQ-005 Port en  in  1  count enable; 0 holds the count.
REQ-006 Port mode  in  1  direction; 1 = up, 0 = down.
REQ-007 Port load  in  1  parallel load strobe.
REQ-008 Port data_in  in  WIDTH  load value.
REQ-009 Port data_out  out  WIDTH  registered count.
REQ-010 Port carry_out  out  1  combinational cascade strobe.
REQ-011 Port load_err  out  1  registered one-cycle flag for an out-of-range load.

Function
REQ-012 Per-cycle priority SHALL be: rst > load > (en and count) > hold.
REQ-013 Load with data_in < MODULUS SHALL set data_out <= data_in and load_err <= 0, ignoring en and mode.
REQ-014 Load with data_in >= MODULUS SHALL set data_out <= MODULUS-1 and load_err <= 1 for exactly that next cycle.
REQ-015 load_err SHALL be 0 in every cycle not caused by REQ-014.
REQ-016 With en=1, mode=1 and no load: data_out == MODULUS-1 SHALL wrap to 0; otherwise data_out SHALL increment by 1.
REQ-017 With en=1, mode=0 and no load: data_out == 0 SHALL wrap to MODULUS-1; otherwise data_out SHALL decrement by 1.
REQ-018 With en=0 and no load, data_out SHALL hold.
REQ-019 carry_out SHALL equal en & ~load & ~rst & ((mode & data_out==MODULUS-1) | (~mode & data_out==0)), so it is high in the same cycle that precedes a wrap.
REQ-020 Cascading SHALL be done by tying a stage's en to the lower stage's carry_out. A chain of N stages SHALL count 0..MODULUS**N-1 with no extra logic.
REQ-021 A direction change SHALL take effect on the next enabled edge, with no dead cycle.
REQ-022 data_out SHALL never leave the range 0..MODULUS-1 after the first reset.
REQ-023 Arithmetic SHALL be WIDTH bits wide. When MODULUS == 2**WIDTH, the wrap SHALL match natural overflow.

Reset
REQ-024 When rst=1 at a clock edge: data_out <= 0, load_err <= 0, and the optional wrap_count <= 0.
REQ-025 Reset SHALL override a simultaneous load or count.
REQ-026 Asserting rst in the middle of a count sequence SHALL lose no further cycles; counting SHALL resume from 0 on the first edge after rst deasserts.
REQ-027 carry_out SHALL be 0 while rst=1.

Configuration
REQ-028 Macro MODN_CNT_WRAP_COUNT_EN, when defined, SHALL add port wrap_count  out  8  registered.
REQ-029 wrap_count SHALL increment on every edge where carry_out=1 (up-wrap or down-wrap) and SHALL saturate at 255.
REQ-030 A load SHALL not change wrap_count. Only rst SHALL clear it.
REQ-031 Without the macro, the port and its register SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Defaults, rst 1 cycle, then en=1, mode=1 for 12 cycles -> data_out 1..9,0,1,2. carry_out high only while data_out==9.
REQ-033 Defaults, load data_in=3 then en=1, mode=0 for 5 cycles -> data_out 3,2,1,0,9,8. carry_out high only while data_out==0.
REQ-034 Defaults, load data_in=13 -> data_out=9 and load_err=1 for one cycle, then 0. Load with data_in=7 -> data_out=7 and load_err=0.
REQ-035 Defaults, data_out=5 with rst=1, load=1, data_in=2 and en=1 in the same cycle -> data_out=0. Then en=1, mode=1 -> data_out=1.
REQ-036 Two stages cascaded (lower carry_out drives upper en), up from 0 for 100 cycles -> {upper,lower} reads 9,9 at cycle 99 and 0,0 at cycle 100.
REQ-037 MODULUS=16, WIDTH=4, MODN_CNT_WRAP_COUNT_EN defined, up for 40 cycles -> data_out=8 and wrap_count=2. Counting on past 4096 wraps -> wrap_count stays at 255.
